// File: rtl/ultra_beam_layer_compositor.sv
// rtl/ultra_beam_layer_compositor.sv - two-stage layer compositor with flash/fade screen effects
// Stage 1 picks the visible colour, stage 2 applies the effect FSM; sync rides along both stages.
module ultra_beam_layer_compositor #(
   parameter int LAYERS       = 2,
   parameter int COLOR_W      = 4,
   parameter int H_BITS       = 11,
   parameter int V_BITS       = 10,
   parameter int FIELD_X_MIN  = 341,
   parameter int FIELD_X_MAX  = 682,
   parameter logic [3*COLOR_W-1:0] BG_COLOR = {3{{COLOR_W{1'b1}}}},
   parameter int FLASH_FRAMES = 8,
   parameter int FADE_DIV     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [H_BITS-1:0]             beam_x,
   input  logic [V_BITS-1:0]             beam_y,
   input  logic                          draw,
   input  logic [1:0]                    sync_in,
   input  logic [LAYERS*3*COLOR_W-1:0]   layer_colors,
   input  logic [LAYERS-1:0]             layer_transparent,
   input  logic                          frame_tick,
   input  logic                          flash_req,
   input  logic                          fade_req,
   input  logic                          fade_clear,
   output logic [COLOR_W-1:0]            red,
   output logic [COLOR_W-1:0]            green,
   output logic [COLOR_W-1:0]            blue,
   output logic [1:0]                    sync_out,
   output logic                          fx_busy
);

   localparam int FCNT_MAX = (FLASH_FRAMES > FADE_DIV) ? FLASH_FRAMES : FADE_DIV;
   localparam int FCNT_W   = $clog2(FCNT_MAX + 1);
   localparam int PIX_W    = 3 * COLOR_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FLASH = 2'd1;
   localparam logic [1:0] S_FADE  = 2'd2;
   localparam logic [1:0] S_DARK  = 2'd3;

   localparam logic [H_BITS-1:0] L_XMIN       = H_BITS'(FIELD_X_MIN);
   localparam logic [H_BITS-1:0] L_XMAX       = H_BITS'(FIELD_X_MAX);
   localparam logic [FCNT_W-1:0] L_FLASH_LAST = FCNT_W'(FLASH_FRAMES - 1);
   localparam logic [FCNT_W-1:0] L_FADE_LAST  = FCNT_W'(FADE_DIV - 1);

   logic [PIX_W-1:0]   w_col;
   logic               w_in_field;
   logic [PIX_W-1:0]   w_fx;
   logic [COLOR_W-1:0] w_shade_inc;
   logic               w_unused_beam_y;

   logic [PIX_W-1:0]   r_s1_col;
   logic               r_s1_in_field;
   logic [1:0]         r_s1_sync;
   logic [PIX_W-1:0]   r_out;
   logic [1:0]         r_sync2;
   logic [1:0]         r_state;
   logic [FCNT_W-1:0]  r_fcnt;
   logic [COLOR_W-1:0] r_shade;

   assign w_unused_beam_y = ^beam_y;
   assign w_shade_inc     = r_shade + 1'b1;

   // Colours are held internally as {b,g,r}; BG_COLOR is given as {r,g,b}.
   always_comb begin
      w_col      = '0;
      w_in_field = 1'b0;
      if (draw && (beam_x >= L_XMIN) && (beam_x < L_XMAX)) begin
         w_in_field = 1'b1;
         w_col      = {BG_COLOR[COLOR_W-1:0], BG_COLOR[2*COLOR_W-1:COLOR_W], BG_COLOR[3*COLOR_W-1:2*COLOR_W]};
         for (int l = LAYERS - 1; l >= 0; l--) begin
            if (!layer_transparent[l]) w_col = layer_colors[l*PIX_W +: PIX_W];
         end
      end
   end

   always_comb begin
      w_fx = r_s1_col;
      case (r_state)
         S_FLASH: w_fx = r_s1_in_field ? ~r_s1_col : '0;
         S_FADE: begin
            for (int c = 0; c < 3; c++) begin
               w_fx[c*COLOR_W +: COLOR_W] = (r_s1_col[c*COLOR_W +: COLOR_W] > r_shade) ?
                                            (r_s1_col[c*COLOR_W +: COLOR_W] - r_shade) : '0;
            end
         end
         S_DARK:  w_fx = '0;
         default: w_fx = r_s1_col;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_col      <= '0;
         r_s1_in_field <= 1'b0;
         r_s1_sync     <= '0;
         r_out         <= '0;
         r_sync2       <= '0;
      end else begin
         r_s1_col      <= w_col;
         r_s1_in_field <= w_in_field;
         r_s1_sync     <= sync_in;
         r_out         <= w_fx;
         r_sync2       <= r_s1_sync;
      end
   end

   // Requests are resolved before frame_tick, so a tick arriving with a start request is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_fcnt  <= '0;
         r_shade <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_FLASH: begin
               if (fade_req && !fade_clear) begin
                  r_state <= S_FADE;
                  r_fcnt  <= '0;
                  r_shade <= '0;
               end else if (flash_req) begin
                  r_state <= S_FLASH;
                  r_fcnt  <= '0;
               end else if (r_state == S_FLASH && frame_tick) begin
                  if (r_fcnt == L_FLASH_LAST) begin
                     r_state <= S_IDLE;
                     r_fcnt  <= '0;
                  end else begin
                     r_fcnt <= r_fcnt + 1'b1;
                  end
               end
            end
            S_FADE: begin
               if (fade_clear) begin
                  r_state <= S_IDLE;
                  r_fcnt  <= '0;
                  r_shade <= '0;
               end else if (frame_tick) begin
                  if (r_fcnt == L_FADE_LAST) begin
                     r_fcnt  <= '0;
                     r_shade <= w_shade_inc;
                     if (&w_shade_inc) r_state <= S_DARK;
                  end else begin
                     r_fcnt <= r_fcnt + 1'b1;
                  end
               end
            end
            default: begin
               if (fade_clear) begin
                  r_state <= S_IDLE;
                  r_fcnt  <= '0;
                  r_shade <= '0;
               end
            end
         endcase
      end
   end

   assign red      = r_out[COLOR_W-1:0];
   assign green    = r_out[2*COLOR_W-1:COLOR_W];
   assign blue     = r_out[3*COLOR_W-1:2*COLOR_W];
   assign sync_out = r_sync2;
   assign fx_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_ultra_beam_layer_compositor.sv
// tb/tb_ultra_beam_layer_compositor.sv - directed vector bench for ultra_beam_layer_compositor
module tb_ultra_beam_layer_compositor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] beam_x;
   logic [9:0]  beam_y;
   logic        draw;
   logic [1:0]  sync_in;
   logic [23:0] layer_colors;
   logic [1:0]  layer_transparent;
   logic        frame_tick, flash_req, fade_req, fade_clear;
   logic [3:0]  red, green, blue;
   logic [1:0]  sync_out;
   logic        fx_busy;

   int checks = 0;
   int errors = 0;

   ultra_beam_layer_compositor dut (
      .clk(clk), .rst_n(rst_n), .beam_x(beam_x), .beam_y(beam_y), .draw(draw),
      .sync_in(sync_in), .layer_colors(layer_colors), .layer_transparent(layer_transparent),
      .frame_tick(frame_tick), .flash_req(flash_req), .fade_req(fade_req), .fade_clear(fade_clear),
      .red(red), .green(green), .blue(blue), .sync_out(sync_out), .fx_busy(fx_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [10:0] x;
      logic        d;
      logic [23:0] cols;
      logic [1:0]  tr;
      logic [1:0]  sy;
      logic [13:0] exp_rgbs;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input logic [10:0] x, input logic [23:0] cols, input logic [1:0] tr);
      @(negedge clk);
      beam_x = x; draw = 1'b1; layer_colors = cols; layer_transparent = tr;
   endtask

   task automatic pulse(input int which);
      @(negedge clk);
      case (which)
         0: frame_tick = 1'b1;
         1: flash_req  = 1'b1;
         2: fade_req   = 1'b1;
         3: fade_clear = 1'b1;
         4: begin flash_req = 1'b1; fade_req = 1'b1; end
         default: begin fade_clear = 1'b1; fade_req = 1'b1; end
      endcase
      @(negedge clk);
      frame_tick = 1'b0; flash_req = 1'b0; fade_req = 1'b0; fade_clear = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) pulse(0);
   endtask

   initial begin
      vecs[0] = '{"prio_l0",     11'd400, 1'b1, {12'h0F0, 12'h3A5}, 2'b00, 2'b01, {4'h5, 4'hA, 4'h3, 2'b01}};
      vecs[1] = '{"prio_l1",     11'd400, 1'b1, {12'h0F0, 12'h3A5}, 2'b01, 2'b01, {4'h0, 4'hF, 4'h0, 2'b01}};
      vecs[2] = '{"prio_bg",     11'd400, 1'b1, {12'h0F0, 12'h3A5}, 2'b11, 2'b10, {4'hF, 4'hF, 4'hF, 2'b10}};
      vecs[3] = '{"edge_340",    11'd340, 1'b1, {12'h000, 12'hFFF}, 2'b10, 2'b11, {4'h0, 4'h0, 4'h0, 2'b11}};
      vecs[4] = '{"edge_341",    11'd341, 1'b1, {12'h000, 12'hFFF}, 2'b10, 2'b00, {4'hF, 4'hF, 4'hF, 2'b00}};
      vecs[5] = '{"edge_681",    11'd681, 1'b1, {12'h000, 12'hFFF}, 2'b10, 2'b01, {4'hF, 4'hF, 4'hF, 2'b01}};
      vecs[6] = '{"edge_682",    11'd682, 1'b1, {12'h000, 12'hFFF}, 2'b10, 2'b00, {4'h0, 4'h0, 4'h0, 2'b00}};
      vecs[7] = '{"draw_off",    11'd400, 1'b0, {12'h000, 12'hFFF}, 2'b10, 2'b00, {4'h0, 4'h0, 4'h0, 2'b00}};

      rst_n = 1'b0; beam_x = '0; beam_y = 10'd20; draw = 1'b0; sync_in = '0;
      layer_colors = '0; layer_transparent = '0;
      frame_tick = 0; flash_req = 0; fade_req = 0; fade_clear = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", {red, green, blue, sync_out, fx_busy}, 15'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         beam_x = vecs[i].x; draw = vecs[i].d; layer_colors = vecs[i].cols;
         layer_transparent = vecs[i].tr; sync_in = vecs[i].sy;
         settle();
         check(vecs[i].name, {red, green, blue, sync_out}, vecs[i].exp_rgbs);
      end
      sync_in = 2'b00;

      // Latency: a new pixel must not show after one edge but must after two.
      set_pix(11'd400, {12'h000, 12'hFFF}, 2'b10);
      @(posedge clk); #1;
      check("latency_1", red, 4'h0);
      @(posedge clk); #1;
      check("latency_2", red, 4'hF);

      // Flash on the background pixel.
      set_pix(11'd400, 24'h0, 2'b11);
      pulse(1);
      settle();
      check("flash_inv", {red, green, blue, 3'b000, fx_busy}, 16'h0001);
      set_pix(11'd100, 24'h0, 2'b11);
      settle();
      check("flash_outside", {red, green, blue}, 12'h000);
      set_pix(11'd400, 24'h0, 2'b11);
      ticks(7);
      settle();
      check("flash_t7", {red, fx_busy}, 5'b0000_1);
      ticks(1);
      settle();
      check("flash_end", {red, fx_busy}, 5'b1111_0);

      pulse(1);
      ticks(5);
      pulse(1);
      ticks(7);
      settle();
      check("flash_ext_t12", {red, fx_busy}, 5'b0000_1);
      ticks(1);
      settle();
      check("flash_ext_t13", {red, fx_busy}, 5'b1111_0);

      // Fade from IDLE on the white background.
      pulse(2);
      settle();
      check("fade_t0", {red, fx_busy}, 5'b1111_1);
      ticks(3);
      settle();
      check("fade_t3", red, 4'hF);
      ticks(1);
      settle();
      check("fade_t4", red, 4'hE);
      ticks(4);
      settle();
      check("fade_t8", {red, green, blue}, 12'hDDD);
      ticks(51);
      settle();
      check("fade_t59", red, 4'h1);
      ticks(1);
      settle();
      check("fade_dark", {red, green, blue, 3'b000, fx_busy}, 16'h0001);
      pulse(1);
      settle();
      check("dark_ignores_flash", {red, fx_busy}, 5'b0000_1);
      pulse(3);
      settle();
      check("fade_clear", {red, fx_busy}, 5'b1111_0);

      // Conflicts.
      pulse(4);
      settle();
      check("fade_beats_flash", {red, fx_busy}, 5'b1111_1);
      pulse(3);
      settle();
      check("clear_back_idle", fx_busy, 1'b0);
      pulse(5);
      settle();
      check("clear_beats_fade", {red, fx_busy}, 5'b1111_0);

      // Asynchronous reset in the middle of a fade with shade 7.
      pulse(2);
      ticks(28);
      settle();
      check("fade_shade7", red, 4'h8);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_reset", {red, green, blue, sync_out, fx_busy}, 15'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_pix(11'd400, {12'h000, 12'hFFF}, 2'b10);
      settle();
      check("after_reset", {red, green, blue, 3'b000, fx_busy}, 16'hFFF0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
